// File: rtl/fifo_flex.sv
// Synchronous FIFO with arbitrary depth, occupancy count, programmable
// almost-full/almost-empty thresholds, sticky error flags and selectable read mode.
module fifo_flex #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 32,
    parameter int FWFT      = 1,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [WIDTH-1:0]     din,
    output logic                 full,
    output logic                 almost_full,
    input  logic                 rd_en,
    output logic [WIDTH-1:0]     dout,
    output logic                 dout_valid,
    output logic                 empty,
    output logic                 almost_empty,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 overflow,
    output logic                 underflow,
    input  logic                 clr_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [PTR_W-1:0]     LP_PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] LP_DEPTH    = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] LP_AF       = CNT_WIDTH'(AF_THRESH);
    localparam logic [CNT_WIDTH-1:0] LP_AE       = CNT_WIDTH'(AE_THRESH);

    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 r_overflow;
    logic                 r_underflow;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_wr_acc;
    logic                 w_rd_acc;
    logic [PTR_W-1:0]     w_wr_ptr_nxt;
    logic [PTR_W-1:0]     w_rd_ptr_nxt;
    logic [WIDTH-1:0]     w_head;

    // Flags come only from the registered count, so they lag the causing edge by one cycle.
    assign w_full  = (r_count == LP_DEPTH);
    assign w_empty = (r_count == '0);

    assign w_wr_acc = wr_en && !w_full;
    assign w_rd_acc = rd_en && !w_empty;

    // Explicit wrap keeps non-power-of-two depths correct.
    assign w_wr_ptr_nxt = (r_wr_ptr == LP_PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
    assign w_rd_ptr_nxt = (r_rd_ptr == LP_PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);

    assign w_head = r_mem[r_rd_ptr];

    // Storage has no reset so it can map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (w_wr_acc && !rst) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CNT_WIDTH'(1);
                2'b01:   r_count <= r_count - CNT_WIDTH'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A new error event in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign dout       = w_head;
            assign dout_valid = !w_empty;
        end else begin : g_reg
            logic [WIDTH-1:0] r_dout;
            logic             r_dout_valid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_dout       <= '0;
                    r_dout_valid <= 1'b0;
                end else begin
                    r_dout_valid <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_dout <= w_head;
                    end
                end
            end

            assign dout       = r_dout;
            assign dout_valid = r_dout_valid;
        end
    endgenerate

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= LP_AF);
    assign almost_empty = (r_count <= LP_AE);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_flex.sv
// Drives a FWFT and a registered-output FIFO with identical stimulus and
// compares both against a queue-based reference model.
module tb_fifo_flex;

    localparam int WIDTH = 8;
    localparam int DEPTH = 5;
    localparam int AF    = 3;
    localparam int AE    = 1;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en;
    logic             rd_en;
    logic             clr_err;
    logic [WIDTH-1:0] din;

    logic             full_f, af_f, empty_f, ae_f, dv_f, ovf_f, unf_f;
    logic [WIDTH-1:0] dout_f;
    logic [CW-1:0]    count_f;
    logic             full_r, af_r, empty_r, ae_r, dv_r, ovf_r, unf_r;
    logic [WIDTH-1:0] dout_r;
    logic [CW-1:0]    count_r;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] m_q[$];
    logic             m_ovf;
    logic             m_unf;
    logic [WIDTH-1:0] m_dout;
    logic             m_dv;

    always #5 clk = ~clk;

    fifo_flex #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1), .AF_THRESH(AF), .AE_THRESH(AE)) u_dut_f (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .full(full_f), .almost_full(af_f),
        .rd_en(rd_en), .dout(dout_f), .dout_valid(dv_f), .empty(empty_f), .almost_empty(ae_f),
        .count(count_f), .overflow(ovf_f), .underflow(unf_f), .clr_err(clr_err)
    );

    fifo_flex #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(0), .AF_THRESH(AF), .AE_THRESH(AE)) u_dut_r (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .full(full_r), .almost_full(af_r),
        .rd_en(rd_en), .dout(dout_r), .dout_valid(dv_r), .empty(empty_r), .almost_empty(ae_r),
        .count(count_r), .overflow(ovf_r), .underflow(unf_r), .clr_err(clr_err)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the FIFO is just a bounded queue plus two sticky bits.
    task automatic model_edge(input logic wr, input logic rd, input logic [WIDTH-1:0] d,
                              input logic clr, input logic r);
        int  n;
        logic was_full, was_empty;
        n         = m_q.size();
        was_full  = (n == DEPTH);
        was_empty = (n == 0);
        if (r) begin
            m_q.delete();
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            m_dout = '0;
            m_dv   = 1'b0;
        end else begin
            if (clr) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            if (wr && was_full)  m_ovf = 1'b1;
            if (rd && was_empty) m_unf = 1'b1;
            m_dv = 1'b0;
            if (rd && !was_empty) begin
                m_dout = m_q.pop_front();
                m_dv   = 1'b1;
            end
            if (wr && !was_full) m_q.push_back(d);
        end
    endtask

    task automatic check_all();
        int n;
        logic [3:0] exp_flags;
        n = m_q.size();
        exp_flags = {n == DEPTH, n == 0, n >= AF, n <= AE};
        check_val("count_f", 32'(count_f), 32'(n));
        check_val("count_r", 32'(count_r), 32'(n));
        check_val("flags_f", 32'({full_f, empty_f, af_f, ae_f}), 32'(exp_flags));
        check_val("flags_r", 32'({full_r, empty_r, af_r, ae_r}), 32'(exp_flags));
        check_val("err_f", 32'({ovf_f, unf_f}), 32'({m_ovf, m_unf}));
        check_val("err_r", 32'({ovf_r, unf_r}), 32'({m_ovf, m_unf}));
        check_val("dv_f", 32'(dv_f), 32'(n != 0));
        if (n != 0) check_val("dout_f", 32'(dout_f), 32'(m_q[0]));
        check_val("dv_r", 32'(dv_r), 32'(m_dv));
        check_val("dout_r", 32'(dout_r), 32'(m_dout));
    endtask

    task automatic step(input logic wr, input logic rd, input logic [WIDTH-1:0] d,
                        input logic clr, input logic r);
        wr_en   = wr;
        rd_en   = rd;
        din     = d;
        clr_err = clr;
        rst     = r;
        model_edge(wr, rd, d, clr, r);
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        int p_wr;
        int p_rd;
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; rst = 1'b1; din = '0;
        m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0; m_dv = 1'b0;

        // reset, fill, overflow on a full FIFO
        step(0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h11 + i), 0, 0);
        step(1, 0, 8'h16, 0, 0);
        // drain past empty, then wrap
        for (int i = 0; i < 7; i++) step(0, 1, 8'h00, 0, 0);
        step(1, 0, 8'h20, 0, 0);
        step(1, 0, 8'h21, 0, 0);
        step(0, 1, 8'h00, 0, 0);
        step(0, 1, 8'h00, 0, 0);
        step(0, 0, 8'h00, 1, 0);
        // registered read latency and hold
        step(1, 0, 8'hA5, 0, 0);
        step(0, 1, 8'h00, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        // simultaneous access at count 3, then at count 0
        for (int i = 0; i < 3; i++) step(1, 0, 8'(8'h30 + i), 0, 0);
        for (int i = 0; i < 10; i++) step(1, 1, 8'(8'h40 + i), 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 8'h00, 0, 0);
        step(1, 1, 8'h50, 0, 0);
        step(0, 0, 8'h00, 1, 0);
        // overflow clear, clear colliding with a new overflow, reset mid-operation
        for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h60 + i), 0, 0);
        step(1, 0, 8'h6F, 0, 0);
        step(0, 0, 8'h00, 1, 0);
        step(1, 0, 8'h70, 0, 0);
        step(1, 0, 8'h71, 1, 0);
        step(0, 1, 8'h00, 0, 0);
        step(0, 0, 8'h00, 0, 1);
        step(0, 0, 8'h00, 0, 0);

        // random phases that lean toward full or toward empty
        for (int ph = 0; ph < 8; ph++) begin
            p_wr = (ph % 2 == 0) ? 75 : 30;
            p_rd = (ph % 2 == 0) ? 30 : 75;
            for (int c = 0; c < 300; c++) begin
                step(($urandom_range(99) < p_wr), ($urandom_range(99) < p_rd),
                     8'($urandom), ($urandom_range(19) == 0), ($urandom_range(249) == 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fifo_flex.md
Name: fifo_flex

Overview:
- Parametrised synchronous FIFO; next generation of the team's I/O-circuit FIFO used between the UART/MMIO paths and the CPU.
- Adds arbitrary (non-power-of-two) depth, an occupancy count, programmable almost-full/almost-empty flags and sticky overflow/underflow error flags.
- Selectable read mode: first-word-fall-through (FWFT) or registered-output with a data-valid strobe.
- Single clock domain.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 32, number of entries; any integer >= 2, not necessarily a power of two.
- FWFT, 1, read mode: 1 = head word visible combinationally on dout; 0 = dout registered, valid one cycle after an accepted read.
- AF_THRESH, DEPTH-2, almost_full asserted when count >= AF_THRESH.
- AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH.
- CNT_WIDTH, $clog2(DEPTH+1), width of the count output.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous active-high reset.
- wr_en  input  1  write request.
- din  input  WIDTH  write data.
- full  output  1  count == DEPTH.
- almost_full  output  1  count >= AF_THRESH.
- rd_en  input  1  read request.
- dout  output  WIDTH  read data (meaning depends on FWFT).
- dout_valid  output  1  FWFT=1: equals !empty. FWFT=0: one-cycle pulse when the registered dout holds newly read data.
- empty  output  1  count == 0.
- almost_empty  output  1  count <= AE_THRESH.
- count  output  CNT_WIDTH  current number of stored entries.
- overflow  output  1  sticky; set by a write attempt while full.
- underflow  output  1  sticky; set by a read attempt while empty.
- clr_err  input  1  clears overflow and underflow.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset state:
  - Write pointer, read pointer and count = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0 (if AF_THRESH > 0).
  - overflow = 0, underflow = 0, dout_valid = 0.
  - dout = 0 in FWFT=0. In FWFT=1 dout is don't-care while empty.
  - Memory contents are not reset.
  - rst asserted mid-operation discards all stored data on that edge; rst wins over every other input.
- Write acceptance: accepted iff wr_en && !full (full sampled before the edge). On acceptance, din is stored at the write pointer and the write pointer advances.
- Read acceptance: accepted iff rd_en && !empty. On acceptance the read pointer advances.
- Pointer wrap: pointers are log2-sized indices in 0..DEPTH-1. An index at DEPTH-1 wraps to 0 explicitly; no modulo-by-power-of-two shortcut.
- Count: count += accepted write, -= accepted read. A simultaneous accepted write and read leaves count unchanged.
- Flags: full, empty, almost_full and almost_empty are derived combinationally from the registered count. All update the cycle after the causing edge.
- Simultaneous rd_en and wr_en:
  - When empty: only the write is accepted; the read is rejected and underflow is set.
  - When full: only the read is accepted; the write is rejected and overflow is set. There is no pass-through.
- FWFT=1: dout = mem[rd_ptr] combinationally. Read latency is 0; rd_en acts as an acknowledge of the current dout.
- FWFT=0:
  - On an accepted read, dout <= mem[rd_ptr] and dout_valid <= 1 for exactly one cycle.
  - Otherwise dout holds its value and dout_valid <= 0.
  - Read latency is 1 cycle.
- Error flags:
  - overflow <= 1 on wr_en && full; underflow <= 1 on rd_en && empty.
  - Both remain set until clr_err or rst.
  - If clr_err coincides with a new error event, set wins.
- Synthesis: memory inferred as distributed or block RAM; no combinational path from din to dout.

Test Plan:
- Reset then fill: DEPTH=5, FWFT=1, 5 writes of 0x11..0x15. count increments to 5; full=1 after the 5th. almost_full=1 once count>=3. A 6th write is dropped, overflow=1, and the memory is unchanged.
- Drain and wrap: continuing from the fill, perform 7 reads. dout shows 0x11..0x15 in order and empty=1 after the 5th read. Reads 6 and 7 set underflow. Then write 0x20 and 0x21 and read both: pointers wrap past index 4 and 0x20, 0x21 are returned correctly.
- Registered mode: FWFT=0, write 0xA5 then read. dout=0xA5 with dout_valid=1 exactly one cycle after the rd_en edge, then dout_valid=0 while dout holds 0xA5.
- Simultaneous access: with count=3, assert wr_en and rd_en for 10 cycles with an incrementing din. count stays 3 and the output order is preserved. With count=0, the same stimulus for 1 cycle gives count=1 and underflow=1.
- Error clear and reset: with overflow=1, pulse clr_err; overflow drops next cycle. Assert clr_err together with a write into a full FIFO; overflow stays 1. Assert rst with count=4; next cycle count=0, empty=1, and the flags match the reset values.
